// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with valid/ready fetch handshake, jump/jr/branch redirect and range fault.
// Optional macro PC_SEQ_DELAY_SLOT_EN enables a single architectural delay slot.
`default_nettype none

module pc_sequencer #(
    parameter int ADDR_W     = 32,
    parameter int IMEM_DEPTH = 256,
    parameter int RESET_PC   = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    output logic              fetch_valid,
    input  logic              fetch_ready,
    output logic [ADDR_W-1:0] pc,
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic [25:0]       jump_addr,
    input  logic [ADDR_W-1:0] rs_content,
    input  logic [15:0]       immediate,
    input  logic              branch_signal,
    input  logic              alu_zero,
    output logic              halted,
    output logic              error
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    localparam logic [ADDR_W-1:0] PC_INIT  = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W:0]   PC_LIMIT = (ADDR_W+1)'(IMEM_DEPTH);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [ADDR_W-1:0] pc_reg;
    logic              error_reg;

    logic              transfer;
    logic              is_jump;
    logic              is_jr;
    logic              is_taken;
    logic              redirect;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] next_pc;
    logic              out_of_range;

    assign fetch_valid = (state == ST_FETCH);
    assign halted      = (state == ST_HALT);
    assign pc          = pc_reg;
    assign error       = error_reg;

    assign transfer = fetch_valid & fetch_ready;
    assign is_jump  = (opcode == 6'h02);
    assign is_jr    = (opcode == 6'h00) && (funct == 6'h08);
    assign is_taken = branch_signal & alu_zero;
    assign redirect = is_jump | is_jr | is_taken;
    assign pc_inc   = pc_reg + ADDR_W'(1);

    // Priority order: jump, then jr, then taken branch.
    assign target = is_jump ? ADDR_W'(jump_addr) :
                    is_jr   ? rs_content :
                              pc_inc + ADDR_W'(signed'(immediate));

`ifdef PC_SEQ_DELAY_SLOT_EN
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_pc;

    // The delay-slot instruction runs at pc+1; a redirect it carries is dropped.
    assign next_pc = pend_valid ? pend_pc : pc_inc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend_pc    <= '0;
        end else if (transfer) begin
            if (pend_valid) begin
                pend_valid <= 1'b0;
            end else if (redirect) begin
                pend_valid <= 1'b1;
                pend_pc    <= target;
            end
        end
    end
`else
    assign next_pc = redirect ? target : pc_inc;
`endif

    assign out_of_range = ({1'b0, next_pc} >= PC_LIMIT);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (run) state_nxt = ST_FETCH;
            ST_FETCH: begin
                if (transfer && out_of_range) state_nxt = ST_HALT;
                else if (!run)                state_nxt = ST_IDLE;
            end
            ST_HALT:  state_nxt = ST_HALT;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            pc_reg    <= PC_INIT;
            error_reg <= 1'b0;
        end else begin
            state <= state_nxt;
            if (transfer && !out_of_range) pc_reg <= next_pc;
            if (transfer && out_of_range)  error_reg <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed plus randomized checking of pc_sequencer against a behavioural model.
`default_nettype none

module tb_pc_sequencer;

    localparam int     AW    = 32;
    localparam int     DEPTH = 64;
    localparam longint MASK  = 64'hFFFF_FFFF;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          run = 1'b0;
    logic          fetch_ready = 1'b0;
    logic          branch_signal = 1'b0;
    logic          alu_zero = 1'b0;
    logic [5:0]    opcode = '0;
    logic [5:0]    funct = '0;
    logic [25:0]   jump_addr = '0;
    logic [AW-1:0] rs_content = '0;
    logic [15:0]   immediate = '0;
    logic          fetch_valid;
    logic          halted;
    logic          error;
    logic [AW-1:0] pc;

    int checks = 0;
    int errors = 0;

    // Model: 0 = idle, 1 = fetching, 2 = halted
    int     m_mode;
    longint m_pc;
    bit     m_err;
    bit     m_pend;
    longint m_pend_pc;

    always #5 clock = ~clock;

    pc_sequencer #(
        .ADDR_W     (AW),
        .IMEM_DEPTH (DEPTH),
        .RESET_PC   (0)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .run           (run),
        .fetch_valid   (fetch_valid),
        .fetch_ready   (fetch_ready),
        .pc            (pc),
        .opcode        (opcode),
        .funct         (funct),
        .jump_addr     (jump_addr),
        .rs_content    (rs_content),
        .immediate     (immediate),
        .branch_signal (branch_signal),
        .alu_zero      (alu_zero),
        .halted        (halted),
        .error         (error)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_pc   = 0;
        m_err  = 1'b0;
        m_pend = 1'b0;
    endtask

    task automatic compare_all();
        check("pc", pc, m_pc);
        check("fetch_valid", fetch_valid, m_mode == 1);
        check("halted", halted, m_mode == 2);
        check("error", error, m_err);
    endtask

    task automatic model_step();
        longint tgt;
        longint nxt;
        bit     redir;
        if (m_mode == 1) begin
            if (fetch_ready) begin
                redir = 1'b1;
                tgt   = 0;
                if (opcode == 6'h02)                         tgt = longint'(jump_addr);
                else if (opcode == 6'h00 && funct == 6'h08)  tgt = longint'(rs_content);
                else if (branch_signal && alu_zero)          tgt = (m_pc + 1 + longint'($signed(immediate))) & MASK;
                else                                         redir = 1'b0;
`ifdef PC_SEQ_DELAY_SLOT_EN
                if (m_pend) begin
                    nxt    = m_pend_pc;
                    m_pend = 1'b0;
                end else begin
                    nxt = (m_pc + 1) & MASK;
                    if (redir) begin
                        m_pend    = 1'b1;
                        m_pend_pc = tgt;
                    end
                end
`else
                nxt = redir ? tgt : ((m_pc + 1) & MASK);
`endif
                if (nxt >= DEPTH) begin
                    m_err  = 1'b1;
                    m_mode = 2;
                    return;
                end
                m_pc = nxt;
            end
            if (!run) m_mode = 0;
        end else if (m_mode == 0 && run) begin
            m_mode = 1;
        end
    endtask

    task automatic step(input bit r, input bit rdy, input logic [5:0] op, input logic [5:0] fn,
                        input logic [25:0] ja, input logic [AW-1:0] rs, input logic [15:0] imm,
                        input bit br, input bit z);
        @(negedge clock);
        compare_all();
        run           = r;
        fetch_ready   = rdy;
        opcode        = op;
        funct         = fn;
        jump_addr     = ja;
        rs_content    = rs;
        immediate     = imm;
        branch_signal = br;
        alu_zero      = z;
        model_step();
    endtask

    task automatic seq_step();
        step(1, 1, 6'h08, 6'h00, '0, '0, '0, 0, 0);
    endtask

    task automatic peek_pc(input string tag, input logic [63:0] exp);
        @(posedge clock);
        #1;
        check(tag, pc, exp);
    endtask

    // Reset is raised mid-cycle so the outputs must clear without a clock edge.
    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("rst_pc", pc, 0);
        check("rst_fetch_valid", fetch_valid, 0);
        check("rst_halted", halted, 0);
        check("rst_error", error, 0);
        model_reset();
        @(posedge clock);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        do_reset();

`ifndef PC_SEQ_DELAY_SLOT_EN
        repeat (6) seq_step();
        peek_pc("seq_pc5", 5);
        repeat (3) step(1, 0, 6'h08, 6'h00, '0, '0, '0, 0, 0);
        peek_pc("stall_pc5", 5);
        seq_step();
        peek_pc("release_pc6", 6);
        step(1, 1, 6'h02, 6'h00, 26'd10, '0, '0, 0, 0);
        peek_pc("jump_pc10", 10);
        step(1, 1, 6'h04, 6'h00, '0, '0, 16'hFFFC, 1, 1);
        peek_pc("branch_taken_pc7", 7);
        step(1, 1, 6'h02, 6'h00, 26'd10, '0, '0, 0, 0);
        step(1, 1, 6'h04, 6'h00, '0, '0, 16'hFFFC, 1, 0);
        peek_pc("branch_not_taken_pc11", 11);
        step(1, 1, 6'h02, 6'h00, 26'h20, '0, 16'h0005, 1, 1);
        peek_pc("jump_wins_pc20", 32'h20);
        step(1, 1, 6'h00, 6'h08, '0, 32'h33, '0, 0, 0);
        peek_pc("jr_pc33", 32'h33);
        step(1, 1, 6'h02, 6'h00, 26'd63, '0, '0, 0, 0);
        peek_pc("jump_top_pc63", 63);
        seq_step();
        peek_pc("overflow_pc_hold", 63);
        check("overflow_halted", halted, 1);
        check("overflow_error", error, 1);
        repeat (2) seq_step();
        do_reset();
        repeat (3) seq_step();
        step(1, 1, 6'h00, 6'h08, '0, 32'h40, '0, 0, 0);
        peek_pc("jr_oor_pc_hold", 2);
        check("jr_oor_error", error, 1);
        check("jr_oor_fetch_valid", fetch_valid, 0);
        seq_step();
        do_reset();
`else
        repeat (4) seq_step();
        peek_pc("ds_pc3", 3);
        step(1, 1, 6'h02, 6'h00, 26'h20, '0, '0, 0, 0);
        peek_pc("ds_slot_pc4", 4);
        seq_step();
        peek_pc("ds_target_pc20", 32'h20);
        seq_step();
        do_reset();
`endif

        repeat (800) begin
            if (m_mode == 2 || $urandom_range(0, 80) == 0) begin
                do_reset();
            end else begin
                logic [5:0]  op;
                logic [5:0]  fn;
                logic [15:0] imm;
                fn  = 6'h00;
                case ($urandom_range(0, 5))
                    0, 1, 2: op = 6'h08;
                    3:       op = 6'h04;
                    4:       op = 6'h02;
                    default: begin
                        op = 6'h00;
                        fn = ($urandom_range(0, 3) != 0) ? 6'h08 : 6'h20;
                    end
                endcase
                imm = 16'($urandom_range(0, 24)) - 16'd12;
                step($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, op, fn,
                     26'($urandom_range(0, DEPTH + 6)), AW'($urandom_range(0, DEPTH + 6)),
                     imm, $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0);
            end
        end

        @(negedge clock);
        compare_all();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
